// File: rtl/dwc_pcie_axi_rd_pkg.sv
`default_nettype none
//==============================================================================
// Module : dwc_pcie_axi_rd_pkg
// Brief  : Shared encodings, FSM states and R-beat record for the AXI read path
// Rev    : 1.0 - initial release
//==============================================================================
package dwc_pcie_axi_rd_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        c_ST_IDLE  = 1'b0,
        c_ST_BURST = 1'b1
    } state_e;

    // Field widths of the buffered beat; the top's ID_WD/DATA_WD must not exceed these
    localparam int c_RB_ID_WD   = 4;
    localparam int c_RB_DATA_WD = 64;

    typedef struct packed {
        logic [c_RB_ID_WD-1:0]   id;
        logic [c_RB_DATA_WD-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } rbeat_s;

    // Only FIXED and INCR touch memory; WRAP and the reserved code answer SLVERR
    function automatic logic is_mem_burst(input logic [1:0] burst);
        return (burst == c_BURST_FIXED) || (burst == c_BURST_INCR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwc_pcie_axi_rd_rsp_if.sv
`default_nettype none
//==============================================================================
// Module : dwc_pcie_axi_rd_rsp_if
// Brief  : AXI AR/R channel bundle between the fabric and the read responder
// Rev    : 1.0 - initial release
//==============================================================================
interface dwc_pcie_axi_rd_rsp_if #(
    parameter int ID_WD   = 4,
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64
);
    logic               arvalid;
    logic               arready;
    logic [ID_WD-1:0]   arid;
    logic [ADDR_WD-1:0] araddr;
    logic [7:0]         arlen;
    logic [1:0]         arburst;
    logic               rvalid;
    logic               rready;
    logic [ID_WD-1:0]   rid;
    logic [DATA_WD-1:0] rdata;
    logic [1:0]         rresp;
    logic               rlast;

    modport slave (
        input  arvalid, arid, araddr, arlen, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport master (
        output arvalid, arid, araddr, arlen, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface
`default_nettype wire

// File: rtl/dwc_pcie_axi_rd_fifo.sv
`default_nettype none
//==============================================================================
// Module : dwc_pcie_axi_rd_fifo
// Brief  : Shift-down R buffer; entry 0 is the head register driving the R bus
// Rev    : 1.0 - initial release
//==============================================================================
module dwc_pcie_axi_rd_fifo
    import dwc_pcie_axi_rd_pkg::*;
#(
    parameter int FIFO_DEPTH = 3,
    parameter int OCC_WD     = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    input  wire logic              clrn,
    input  wire logic              push,
    input  wire rbeat_s            push_data,
    input  wire logic              pop,
    output rbeat_s                 head,
    output logic                   valid,
    output logic [OCC_WD-1:0]      occ
);

    rbeat_s              r_mem [FIFO_DEPTH];
    rbeat_s              w_shift [FIFO_DEPTH];
    logic [OCC_WD-1:0]   r_occ;
    logic [OCC_WD-1:0]   w_base;
    logic                w_pop;

    assign w_pop  = pop && (r_occ != '0);
    assign w_base = r_occ - OCC_WD'(w_pop);

    for (genvar gi = 0; gi < FIFO_DEPTH - 1; gi++) begin : g_shift
        assign w_shift[gi] = r_mem[gi+1];
    end
    assign w_shift[FIFO_DEPTH-1] = r_mem[FIFO_DEPTH-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clrn) begin
            r_occ <= '0;
        end else begin
            // A push lands in the first free slot as seen after this cycle's pop
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push && (OCC_WD'(i) == w_base)) begin
                    r_mem[i] <= push_data;
                end else if (w_pop) begin
                    r_mem[i] <= w_shift[i];
                end
            end
            r_occ <= r_occ + OCC_WD'(push) - OCC_WD'(w_pop);
        end
    end

    assign head  = r_mem[0];
    assign valid = (r_occ != '0);
    assign occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/dwc_pcie_axi_rd_rsp.sv
`default_nettype none
//==============================================================================
// Module : dwc_pcie_axi_rd_rsp
// Brief  : AXI read responder: AR accept, fixed-latency memory reads, buffered R
// Rev    : 1.0 - initial release
//==============================================================================
module dwc_pcie_axi_rd_rsp
    import dwc_pcie_axi_rd_pkg::*;
#(
    parameter int ID_WD      = 4,
    parameter int ADDR_WD    = 32,
    parameter int DATA_WD    = 64,
    parameter int FIFO_DEPTH = 3,
    parameter int TP         = 0
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    input  wire logic               clrn,
    dwc_pcie_axi_rd_rsp_if.slave    axi,
    output logic                    mem_rd_en,
    output logic [ADDR_WD-1:0]      mem_rd_addr,
    input  wire logic [DATA_WD-1:0] mem_rd_data,
    input  wire logic               mem_rd_err
);

    localparam int c_BEAT_BYTES = DATA_WD / 8;
    localparam int c_OCC_WD     = $clog2(FIFO_DEPTH + 1);
    localparam int c_CRD_WD     = c_OCC_WD + 1;

    // The register model is zero-delay; TP only matters for delay-annotated sim models
    if (TP != 0) begin : g_tp_delayed
    end else begin : g_tp_zero
    end

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_arready;
    logic [ID_WD-1:0]    r_id;
    logic [ADDR_WD-1:0]  r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_cnt;
    logic [1:0]          r_burst;
    logic                r_if_vld;
    logic [ID_WD-1:0]    r_if_id;
    logic                r_if_last;
    logic                r_if_err;

    logic                w_ar_hs;
    logic                w_credit;
    logic                w_issue;
    logic [c_OCC_WD-1:0] w_occ;
    logic                w_fifo_vld;
    rbeat_s              w_head;
    rbeat_s              w_push_beat;

    assign w_ar_hs  = axi.arvalid && r_arready && clrn && (r_state == c_ST_IDLE);
    // Credit looks only at registered state, so rready never reaches mem_rd_en
    assign w_credit = ({1'b0, w_occ} + c_CRD_WD'(r_if_vld)) < c_CRD_WD'(FIFO_DEPTH);
    assign w_issue  = (r_state == c_ST_BURST) && w_credit && clrn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_rd_en   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                mem_rd_en = w_issue && is_mem_burst(r_burst);
                if (w_issue && (r_cnt == r_len)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (!clrn) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_arready <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_if_vld  <= 1'b0;
            r_if_id   <= '0;
            r_if_last <= 1'b0;
            r_if_err  <= 1'b0;
        end else begin
            r_arready <= clrn && (w_state_nxt == c_ST_IDLE);
            if (w_ar_hs) begin
                r_id    <= axi.arid;
                r_addr  <= axi.araddr & ~ADDR_WD'(c_BEAT_BYTES - 1);
                r_len   <= axi.arlen;
                r_burst <= axi.arburst;
                r_cnt   <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + 8'd1;
                if (r_burst == c_BURST_INCR) begin
                    r_addr <= r_addr + ADDR_WD'(c_BEAT_BYTES);
                end
            end
            r_if_vld <= w_issue;
            if (w_issue) begin
                r_if_id   <= r_id;
                r_if_last <= (r_cnt == r_len);
                r_if_err  <= !is_mem_burst(r_burst);
            end
        end
    end

    assign mem_rd_addr = r_addr;

    always_comb begin
        w_push_beat      = '0;
        w_push_beat.id   = c_RB_ID_WD'(r_if_id);
        w_push_beat.data = r_if_err ? '0 : c_RB_DATA_WD'(mem_rd_data);
        w_push_beat.resp = (mem_rd_err || r_if_err) ? c_RESP_SLVERR : c_RESP_OKAY;
        w_push_beat.last = r_if_last;
    end

    dwc_pcie_axi_rd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .OCC_WD     (c_OCC_WD)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .clrn       (clrn),
        .push       (r_if_vld),
        .push_data  (w_push_beat),
        .pop        (w_fifo_vld && axi.rready),
        .head       (w_head),
        .valid      (w_fifo_vld),
        .occ        (w_occ)
    );

    assign axi.arready = r_arready;
    assign axi.rvalid  = w_fifo_vld;
    assign axi.rid     = ID_WD'(w_head.id);
    assign axi.rdata   = DATA_WD'(w_head.data);
    assign axi.rresp   = w_head.resp;
    assign axi.rlast   = w_head.last;

endmodule
`default_nettype wire
